uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Shares one uart_tx byte transmitter between N_REQ frame-oriented requesters, e.g. uart_config, uart_instr acknowledge and status reporters.
- Arbitrates round-robin per frame. The grant is held from the first byte until the requester's last byte, so frames never interleave on the serial line.
- Sits between the requesters and the uart_tx instance and drives its data_in/tx_vld, sampling tx_rdy.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TMO_CYC, 17360, idle cycles tolerated mid-frame before the grant is revoked (bps*20 at bps=868).
- CNT_W, 20, width of the timeout counter; must satisfy TMO_CYC < 2^CNT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_vld  input  N_REQ  per-requester byte valid.
- req_data  input  N_REQ*8  per-requester byte; requester i uses bits [i*8+7:i*8].
- req_last  input  N_REQ  marks final byte of frame, qualified by req_vld.
- req_rdy  output  N_REQ  per-requester byte accept (combinational).
- grant  output  N_REQ  one-hot current owner; 0 when idle.
- busy  output  1  high while any frame is owned.
- abort  output  N_REQ  one-cycle pulse to the owner whose frame timed out.
- data_in  output  8  byte to uart_tx.
- tx_vld  output  1  one-cycle launch pulse to uart_tx.
- tx_rdy  input  1  uart_tx idle/ready.

Behaviour:
- Reset values: all outputs 0 at the clock edge with rst high. Internal values are last_owner=N_REQ-1, state=IDLE, timeout counter=0, holdoff=0. rst mid-frame drops the frame immediately; no further bytes are accepted or launched.
- State IDLE:
  - If req_vld is nonzero, pick the first index with req_vld set, searching (last_owner+1) mod N_REQ upward with wrap.
  - Register grant one-hot, set busy, and move to SEND next cycle. No byte is accepted in the arbitration cycle.
- State SEND:
  - Accept condition: req_rdy[g] = (state==SEND) & tx_rdy & ~holdoff & req_vld[g]. Other req_rdy bits are 0.
  - On accept: data_in <= req_data[g], tx_vld <= 1 for exactly one cycle on the following cycle, holdoff <= 1.
  - holdoff clears 2 cycles after the accept edge. This covers uart_tx's 1-cycle latency in dropping tx_rdy, so consecutive bytes can never double-launch.
  - Byte-to-line latency is 1 cycle from the accept edge to tx_vld.
  - Accept with req_last: last_owner <= g, grant <= 0, busy <= 0, state <= IDLE. The next arbitration may occur the cycle after. Its first accept still waits for holdoff and tx_rdy.
- Timeout:
  - In SEND, the counter increments each cycle in which req_vld[g]=0 and clears on any accept.
  - At count TMO_CYC-1: pulse abort[g] for 1 cycle, grant <= 0, last_owner <= g, state <= IDLE, counter <= 0.
  - Bytes already launched are not recalled.
- Fairness:
  - A requester holding req_vld continuously is served within N_REQ-1 other frames.
  - Simultaneous requests resolve strictly by rotation, not by index.
- A requester raising req_vld while another owns the grant sees req_rdy=0 and must hold its byte stable until accepted.
- req_last on a 1-byte frame is legal: accept, launch, release.
- tx_rdy low in SEND stalls accepts. The timeout counter does not advance while req_vld[g]=1, even if tx_rdy is low.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- When defined:
  - On entering SEND, before the requester's first byte, the arbiter itself launches one header byte {4'hA, 1'b0, g[2:0]}, with the same tx_rdy/holdoff rules. req_rdy stays 0 until the header has been launched.
  - The timeout counter is held at 0 during the header.
- When undefined: there is no header; the first launched byte is the requester's first byte.

Test Plan:
- Reset mid-frame: req0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) with tx_rdy model (drops 1 cycle after tx_vld, returns 10 cycles later), then rst is asserted for 2 cycles after the second tx_vld.
  - Pre-reset: data_in sequence is 0x11,0x22 with tx_vld 1-cycle pulses, grant=0001 during the frame.
  - Post-reset: all outputs 0, no third tx_vld.
- Simultaneous requests: req0 and req2 both assert at cycle 0 from reset; each sends 2-byte frames (0xA0,0xA1 / 0xC0,0xC1).
  - Required line order: 0xA0,0xA1,0xC0,0xC1.
  - A repeat request gives 0xC? before 0xA?, proving rotation.
- Mid-frame contention: req1 asserts mid-frame of req3.
  - req_rdy[1]=0 throughout req3's frame; no interleaving; req1 is served next.
- Timeout: req2 sends byte 0x55 without last, then drops req_vld for TMO_CYC cycles.
  - abort[2] pulses exactly once, TMO_CYC cycles after the accept; grant returns to 0; a subsequent req0 frame proceeds normally.
- Holdoff under tx_rdy tied high: tx_rdy constant 1, req0 streams 4 bytes.
  - tx_vld pulses are spaced at least 2 cycles apart; each data_in matches the accepted byte.
- Header insertion: with UART_ARB_HDR_EN, req1 sends a 1-byte frame 0x7E.
  - Line bytes are 0xA1 then 0x7E.
  - Without the macro: only 0x7E.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx byte transmitter between N_REQ frame-based
// requesters. Arbitration is round-robin per frame. The grant is held from the
// first byte to the byte tagged req_last, so frames never interleave on the line.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_vld/req_data  per-requester byte valid / byte (requester i on [i*8+7:i*8])
//   req_last          final byte of a frame, qualified by req_vld
//   req_rdy           per-requester byte accept (combinational)
//   grant, busy       one-hot current owner (0 when idle), frame-owned flag
//   abort             one-cycle pulse to an owner whose frame timed out
//   data_in, tx_vld   byte and one-cycle launch pulse to uart_tx
//   tx_rdy            uart_tx idle/ready
//
// Optional feature: define UART_ARB_HDR_EN to make the arbiter launch a header
// byte {4'hA, 1'b0, owner[2:0]} ahead of each frame's first byte.
module uart_tx_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TMO_CYC = 17360,
  parameter int unsigned CNT_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [N_REQ*8-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic [N_REQ-1:0]     abort,
  output logic [7:0]           data_in,
  output logic                 tx_vld,
  input  logic                 tx_rdy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             pick_vld;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       hold_cnt;
  logic             sel_vld;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             launch_ok;
  logic             acc;
`ifdef UART_ARB_HDR_EN
  logic             hdr_pend;
  logic             hdr_go;
`endif

  // Round-robin pick: first requester at or after last_owner+1, with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(last_owner) + i) % N_REQ);
      if (!pick_vld && req_vld[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Owner's byte, valid and last, muxed by the one-hot grant.
  always_comb begin
    sel_vld  = |(req_vld & grant);
    sel_last = |(req_last & grant);
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_data = req_data[i*8 +: 8];
    end
  end

  // holdoff (hold_cnt != 0) spans uart_tx's one-cycle delay in dropping tx_rdy.
  always_comb begin
    launch_ok = (state == SEND) && tx_rdy && (hold_cnt == 2'd0);
`ifdef UART_ARB_HDR_EN
    hdr_go = launch_ok && hdr_pend;
    acc    = launch_ok && !hdr_pend && sel_vld;
`else
    acc    = launch_ok && sel_vld;
`endif
  end

  assign req_rdy = grant & {N_REQ{acc}};

  // Arbitration FSM with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      abort      <= '0;
      data_in    <= '0;
      tx_vld     <= 1'b0;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
`ifdef UART_ARB_HDR_EN
      hdr_pend   <= 1'b0;
`endif
    end else begin
      tx_vld <= 1'b0;
      abort  <= '0;
      if (hold_cnt != 2'd0) hold_cnt <= hold_cnt - 2'd1;

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (pick_vld) begin
            grant <= N_REQ'(1) << pick_idx;
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= SEND;
`ifdef UART_ARB_HDR_EN
            hdr_pend <= 1'b1;
`endif
          end
        end

        SEND: begin
`ifdef UART_ARB_HDR_EN
          if (hdr_pend) begin
            tmo_cnt <= '0;
            if (hdr_go) begin
              data_in  <= {4'hA, 1'b0, 3'(owner)};
              tx_vld   <= 1'b1;
              hold_cnt <= 2'd2;
              hdr_pend <= 1'b0;
            end
          end else
`endif
          if (acc) begin
            data_in  <= sel_data;
            tx_vld   <= 1'b1;
            hold_cnt <= 2'd2;
            tmo_cnt  <= '0;
            if (sel_last) begin
              last_owner <= owner;
              grant      <= '0;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (!sel_vld) begin
            // Owner went quiet mid-frame; revoke once the budget is spent.
            if (tmo_cnt == TMO_LAST) begin
              abort      <= grant;
              grant      <= '0;
              busy       <= 1'b0;
              last_owner <= owner;
              tmo_cnt    <= '0;
              state      <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 40;
  localparam int unsigned CW  = 20;
  localparam int unsigned BUDGET = 300;
`ifdef UART_ARB_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_vld = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_rdy;
  logic [N-1:0]   grant;
  logic           busy;
  logic [N-1:0]   abort;
  logic [7:0]     data_in;
  logic           tx_vld;
  logic           tx_rdy = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int n_abort = 0;
  int abort_cyc = 0;
  logic [N-1:0] abort_val = '0;
  int rdy_viol = 0;
  bit tx_tied = 1'b0;
  int tx_busy = 0;
  logic [7:0] line_q[$];
  logic [7:0] exp_q[$];
  int vld_cyc_q[$];

  uart_tx_arb #(.N_REQ(N), .TMO_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_data(req_data), .req_last(req_last), .req_rdy(req_rdy),
    .grant(grant), .busy(busy), .abort(abort),
    .data_in(data_in), .tx_vld(tx_vld), .tx_rdy(tx_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: drops ready the cycle after a launch, returns ~10 cycles later.
  always @(posedge clk) begin
    if (tx_tied) begin
      tx_rdy  <= 1'b1;
      tx_busy <= 0;
    end else if (tx_vld) begin
      tx_rdy  <= 1'b0;
      tx_busy <= 10;
    end else if (tx_busy > 0) begin
      tx_busy <= tx_busy - 1;
      if (tx_busy == 1) tx_rdy <= 1'b1;
    end
  end

  // Line / abort / ready monitor.
  always @(negedge clk) begin
    if (tx_vld) begin
      line_q.push_back(data_in);
      vld_cyc_q.push_back(cyc);
    end
    if (abort != '0) begin
      n_abort++;
      abort_val = abort;
      abort_cyc = cyc;
    end
    if ((req_rdy & ~grant) != '0) rdy_viol++;
    if (grant[3] && req_rdy[1]) rdy_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_hdr(input int g);
    if (HDR) exp_q.push_back(8'hA0 | 8'(g));
  endtask

  task automatic check_line(input string tag);
    chk({tag, "_len"}, 32'(line_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < line_q.size()) chk($sformatf("%s[%0d]", tag, i), 32'(line_q[i]), 32'(exp_q[i]));
    end
    line_q.delete();
    exp_q.delete();
  endtask

  // Present one byte and hold it until the arbiter accepts it (bounded).
  task automatic send_byte(input int i, input logic [7:0] b, input logic last, input string tag);
    bit ok;
    int c;
    ok = 1'b0;
    c = 0;
    req_data[i*8 +: 8] = b;
    req_last[i] = last;
    req_vld[i] = 1'b1;
    while (!ok && c < BUDGET) begin
      @(negedge clk);
      if (req_rdy[i]) ok = 1'b1;
      c++;
    end
    @(posedge clk);
    #1;
    if (ok) last_acc_cyc = cyc;
    req_vld[i] = 1'b0;
    req_last[i] = 1'b0;
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_cyc(3);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_tx_vld", 32'(tx_vld), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    rst = 1'b0;
    line_q.delete();

    // Reset mid-frame: 0x11, 0x22 launched, 0x33 must never go out
    send_byte(0, 8'h11, 1'b0, "t1_acc11");
    chk("t1_grant_a", 32'(grant), 32'h1);
    send_byte(0, 8'h22, 1'b0, "t1_acc22");
    chk("t1_grant_b", 32'(grant), 32'h1);
    req_data[7:0] = 8'h33;
    req_last[0] = 1'b1;
    req_vld[0] = 1'b1;
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(1);
    chk("t1_rst_grant", 32'(grant), 32'd0);
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_tx_vld", 32'(tx_vld), 32'd0);
    wait_cyc(1);
    chk("t1_rst_data_in", 32'(data_in), 32'd0);
    chk("t1_rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("t1_rst_abort", 32'(abort), 32'd0);
    rst = 1'b0;
    req_vld[0] = 1'b0;
    req_last[0] = 1'b0;
    wait_cyc(20);
    chk("t1_idle_grant", 32'(grant), 32'd0);
    exp_hdr(0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check_line("t1_line");

    // Simultaneous requests from reset rotation; req0 re-requests immediately
    fork
      begin
        send_byte(0, 8'hA0, 1'b0, "t2_accA0");
        send_byte(0, 8'hA1, 1'b1, "t2_accA1");
        send_byte(0, 8'hA2, 1'b0, "t2_accA2");
        send_byte(0, 8'hA3, 1'b1, "t2_accA3");
      end
      begin
        send_byte(2, 8'hC0, 1'b0, "t2_accC0");
        send_byte(2, 8'hC1, 1'b1, "t2_accC1");
      end
    join
    wait_cyc(15);
    exp_hdr(0); exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_hdr(2); exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    exp_hdr(0); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    check_line("t2_line");

    // Mid-frame contention: req1 arrives during req3's frame
    rdy_viol = 0;
    fork
      begin
        send_byte(3, 8'h30, 1'b0, "t3_acc30");
        send_byte(3, 8'h31, 1'b0, "t3_acc31");
        send_byte(3, 8'h32, 1'b1, "t3_acc32");
      end
      begin
        wait_cyc(3);
        chk("t3_grant_owner", 32'(grant), 32'h8);
        send_byte(1, 8'h10, 1'b1, "t3_acc10");
      end
    join
    wait_cyc(15);
    chk("t3_rdy_viol", 32'(rdy_viol), 32'd0);
    exp_hdr(3); exp_q.push_back(8'h30); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_hdr(1); exp_q.push_back(8'h10);
    check_line("t3_line");

    // Timeout: req2 goes quiet after one byte
    n_abort = 0;
    send_byte(2, 8'h55, 1'b0, "t4_acc55");
    wait_cyc(TMO + 5);
    chk("t4_abort_cnt", 32'(n_abort), 32'd1);
    chk("t4_abort_val", 32'(abort_val), 32'h4);
    chk("t4_abort_delay", 32'(abort_cyc - last_acc_cyc), 32'(TMO));
    chk("t4_grant", 32'(grant), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    send_byte(0, 8'h01, 1'b0, "t4_acc01");
    chk("t4_grant0", 32'(grant), 32'h1);
    send_byte(0, 8'h02, 1'b1, "t4_acc02");
    wait_cyc(15);
    chk("t4_abort_once", 32'(n_abort), 32'd1);
    exp_hdr(2); exp_q.push_back(8'h55);
    exp_hdr(0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    check_line("t4_line");

    // Holdoff with tx_rdy tied high
    tx_tied = 1'b1;
    wait_cyc(15);
    vld_cyc_q.delete();
    send_byte(0, 8'hB0, 1'b0, "t5_accB0");
    send_byte(0, 8'hB1, 1'b0, "t5_accB1");
    send_byte(0, 8'hB2, 1'b0, "t5_accB2");
    send_byte(0, 8'hB3, 1'b1, "t5_accB3");
    wait_cyc(5);
    chk("t5_pulses", 32'(vld_cyc_q.size()), HDR ? 32'd5 : 32'd4);
    for (int i = 1; i < vld_cyc_q.size(); i++) begin
      chk($sformatf("t5_gap%0d", i), 32'((vld_cyc_q[i] - vld_cyc_q[i-1]) >= 2), 32'd1);
    end
    exp_hdr(0);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
    check_line("t5_line");

    // One-byte frame (header in front when enabled)
    send_byte(1, 8'h7E, 1'b1, "t6_acc7E");
    wait_cyc(5);
    chk("t6_busy", 32'(busy), 32'd0);
    exp_hdr(1);
    exp_q.push_back(8'h7E);
    check_line("t6_line");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
